clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable clock divider. Generates a divided clock-like output (clk_out) and a single-cycle clock-enable strobe (tick) from the board clock.
- The divisor can be reloaded on the fly. A new divisor takes effect only at a period boundary, so no period is ever truncated.
- Feeds the VGA pixel/line timing logic and any slower sub-blocks. Those blocks should use tick as an enable in preference to clocking from clk_out.

Parameters:
- WIDTH, 16, width of the divisor and of the internal counter.
- DEFAULT_DIV, 4, divisor loaded at reset. Legal range 2 .. 2^WIDTH-1.

Ports:
- clk  input  1  board clock
- rst_n  input  1  asynchronous reset, active-low
- en  input  1  count enable; when low, all state holds
- sync_clr  input  1  synchronous restart of the current period
- div_in  input  WIDTH  new divisor value
- div_load  input  1  one-cycle request to load div_in
- div_busy  output  1  a loaded divisor is pending, not yet applied
- clk_out  output  1  divided output, registered
- tick  output  1  one-cycle strobe at the start of each period, registered

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, div_q=DEFAULT_DIV, pend_q=0, pend_v=0.
  - clk_out=0, tick=0, div_busy=0.
- Clamp: any divisor value below 2 (from div_in) is stored as 2.
- Definitions: D = active divisor div_q; H = D>>1 (floor).
- Next count: cnt_n = (cnt == D-1) ? 0 : cnt+1.
- Each edge with en=1 and sync_clr=0:
  - cnt <= cnt_n.
  - clk_out <= (cnt_n < H).
  - tick <= (cnt_n == 0).
- Resulting waveform:
  - Period is exactly D cycles.
  - clk_out is high for H cycles and low for D-H cycles; 50% duty for even D, low-biased by one cycle for odd D.
  - tick is high for one cycle per period, coincident with the first high cycle of clk_out.
- Latency: the first clk_out=1 appears on the first enabled edge after reset (cnt=1 with D≥4). The first tick appears on enabled edge D.
- en=0: cnt and clk_out hold, tick forced to 0 on that edge, and the pending divisor is not applied. div_load is still accepted.
- Load handshake:
  - div_load=1 at an edge sets pend_q <= clamp(div_in) and pend_v <= 1.
  - div_busy = pend_v.
  - A load while busy overwrites pend_q; the last load wins.
- Apply rule:
  - On an enabled edge where cnt_n == 0 and pend_v was already 1 before that edge: div_q <= pend_q, pend_v <= 0.
  - The new D governs the period that starts at that edge. H and cnt_n for the rest of the apply edge use the old D.
- Simultaneous apply and div_load at the same edge: the older pend_q is applied, the new value is stored, and pend_v stays 1.
- sync_clr=1, which has priority over en:
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - If pend_v=1, the pending value is applied immediately and pend_v clears, unless div_load is also high; in that case the new value stays pending.
- Divisor shrink: the new D only takes effect at cnt=0, so cnt never exceeds D-1 and no wrap check beyond ==D-1 is needed.
- D=2: H=1, and clk_out toggles every enabled cycle.
- D=3: clk_out is high 1 cycle, low 2 cycles.
- Reset mid-period or with a load pending: everything returns to reset values and the pending value is lost.
- Arithmetic: cnt is WIDTH bits. cnt+1 cannot overflow because cnt ≤ D-1 ≤ 2^WIDTH-2.

Decomposition:
- Package clk_div_pkg:
  - constant DIV_MIN = 2.
  - clamp function div_clamp(WIDTH-bit value).
- No sub-module is needed; counter, shadow register and output registers fit in one module.
- Optional split: the pend_q/pend_v shadow register as div_shadow_reg, if reused by the line/frame counters.

Test Plan:
- Reset, en=1, D=4: clk_out over edges 1..8 = 1,0,0,1,1,0,0,1. tick high on edges 4 and 8 only.
- D=5 (loaded via div_in=5 plus one div_load, then allowed to apply): steady state shows clk_out high 2 cycles, low 3 cycles, and tick every 5 cycles.
- Mid-period load with D=4 at cnt=1, div_in=6:
  - div_busy=1 for 3 cycles.
  - The current period completes at 4 cycles.
  - The next tick-to-tick interval is 6.
  - div_busy then falls.
- Two loads while busy (div_in=8, then div_in=10): only 10 is applied at the boundary. div_in=0 or 1 results in D=2 (toggle every cycle).
- en low for 3 cycles at cnt=2: cnt and clk_out frozen, tick=0, and the pending divisor is not applied. The sequence resumes exactly where it left off.
- sync_clr with a pending value of 6: next edge gives cnt=0, clk_out=0, tick=0, div_busy=0, D=6. rst_n asserted mid-period returns D to DEFAULT_DIV and clears all outputs asynchronously.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  // Divisors below DIV_MIN would give a zero or one-cycle period, so lift them.
  function automatic logic [31:0] div_clamp(input logic [31:0] v);
    return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between a divider and the block that programs it.
interface clk_div_prog_if #(parameter int WIDTH = 16);
  logic             en;
  logic             sync_clr;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             clk_out;
  logic             tick;

  modport master (output en, sync_clr, div_in, div_load,
                  input  div_busy, clk_out, tick);
  modport slave  (input  en, sync_clr, div_in, div_load,
                  output div_busy, clk_out, tick);
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: registered clk_out plus a one-cycle tick per period.
// Reloaded divisors wait in a shadow register until the next period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_prog_if.slave bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic [WIDTH-1:0] cnt_n, half;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  assign half  = div_q >> 1;
  assign cnt_n = (cnt_q == div_q - WIDTH'(1)) ? '0 : cnt_q + WIDTH'(1);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (bus.div_load) begin
      pend_d   = WIDTH'(div_clamp(32'(bus.div_in)));
      pend_v_d = 1'b1;
    end

    if (bus.sync_clr) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pend_v_q) begin
        div_d = pend_q;
        // A load on this same edge keeps the freshly written value pending.
        if (!bus.div_load) pend_v_d = 1'b0;
      end
    end else if (bus.en) begin
      cnt_d     = cnt_n;
      clk_out_d = (cnt_n < half);
      tick_d    = (cnt_n == '0);
      // The old divisor still governs this edge; the new one owns the next period.
      if (cnt_n == '0 && pend_v_q) begin
        div_d = pend_q;
        if (!bus.div_load) pend_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= WIDTH'(DEFAULT_DIV);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.div_busy = pend_v_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: the driver queues hand-computed {clk_out,tick,div_busy}
// for every edge it drives; an independent monitor pops and compares after each edge.
module tb_clk_div_prog;

  typedef struct {
    string      nm;
    logic [2:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  clk_div_prog_if #(.WIDTH(16)) bus ();

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got co/tk/bz=%b expected %b", nm, got, exp);
    end
  endtask

  // Monitor: every driven edge has exactly one queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, {bus.clk_out, bus.tick, bus.div_busy}, e.exp);
    end
  end

  // Holds the given inputs for len(co) edges, queueing one expectation per edge.
  task automatic drive(input string nm, input logic e, input logic c, input logic ld,
                       input logic [15:0] din, input string co, input string tk,
                       input string bz);
    for (int i = 0; i < co.len(); i++) begin
      exp_t x;
      @(negedge clk);
      bus.en       = e;
      bus.sync_clr = c;
      bus.div_load = ld;
      bus.div_in   = din;
      x.nm  = $sformatf("%s[%0d]", nm, i);
      x.exp = {co[i] == "1", tk[i] == "1", bz[i] == "1"};
      sb.push_back(x);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.sync_clr = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    #1;
    chk(nm, {bus.clk_out, bus.tick, bus.div_busy}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;

    // Default divisor 4 from reset.
    do_reset("reset_state");
    drive("d4", 1, 0, 0, 0, "10011001", "00010001", "00000000");

    // Load 5 on the first edge; applies at edge 4, then 2 high / 3 low.
    do_reset("reset2");
    drive("d5_load", 1, 0, 1, 16'd5, "1", "0", "1");
    drive("d5", 1, 0, 0, 0, "0011000110001", "0010000100001", "1100000000000");

    // Mid-period load of 6: current period finishes at 4, next interval is 6.
    do_reset("reset3");
    drive("d6_load", 1, 0, 1, 16'd6, "1", "0", "1");
    drive("d6", 1, 0, 0, 0, "001110001", "001000001", "110000000");

    // Two loads while busy: last one (10) wins; then a load of 0 clamps to 2.
    do_reset("reset4");
    drive("ld8", 1, 0, 1, 16'd8, "1", "0", "1");
    drive("ld10", 1, 0, 1, 16'd10, "0", "0", "1");
    drive("d10", 1, 0, 0, 0, "011111000001", "010000000001", "100000000000");
    drive("ld0", 1, 0, 1, 16'd0, "1", "0", "1");
    drive("d2", 1, 0, 0, 0, "1110000010101", "0000000010101", "1111111100000");

    // Enable low at cnt=2 with a pending 6, and again right after a tick.
    do_reset("reset5");
    drive("en_ld6", 1, 0, 1, 16'd6, "1", "0", "1");
    drive("en_run", 1, 0, 0, 0, "0", "0", "1");
    drive("en_off", 0, 0, 0, 0, "000", "000", "111");
    drive("en_res", 1, 0, 0, 0, "01", "01", "10");
    drive("en_off2", 0, 0, 0, 0, "1", "0", "0");
    drive("en_d6", 1, 0, 0, 0, "110001", "000001", "000000");

    // sync_clr applies a pending 6 immediately.
    do_reset("reset6");
    drive("clr_ld6", 1, 0, 1, 16'd6, "1", "0", "1");
    drive("clr", 1, 1, 0, 0, "0", "0", "0");
    drive("clr_d6", 1, 0, 0, 0, "110001", "000001", "000000");
    // sync_clr with a simultaneous load: 3 applies, clamp(1)=2 stays pending.
    drive("clr_ld3", 1, 0, 1, 16'd3, "1", "0", "1");
    drive("clr_ld1", 1, 1, 1, 16'd1, "0", "0", "1");
    drive("clr_d3", 1, 0, 0, 0, "00101", "00101", "11000");

    // Mid-period async reset (clk_out is high here) restores divisor 4.
    do_reset("async_rst");
    drive("post_rst", 1, 0, 0, 0, "10011001", "00010001", "00000000");

    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
